// File: rtl/rvfi_mon_pkg.sv
// Shared types for the RVFI retirement monitor: error codes, monitor states, order width.
package rvfi_mon_pkg;

  localparam int unsigned ORDER_W = 64;

  typedef enum logic [3:0] {
    ErrNone     = 4'd0,
    ErrOrder    = 4'd1,
    ErrGap      = 4'd2,
    ErrPc       = 4'd3,
    ErrRs1      = 4'd4,
    ErrRs2      = 4'd5,
    ErrX0Wr     = 4'd6,
    ErrTimeout  = 4'd7,
    ErrPostHalt = 4'd8
  } err_e;

  typedef enum logic [1:0] {
    StRun    = 2'd0,
    StHalted = 2'd1,
    StError  = 2'd2
  } state_e;

endpackage

// File: rtl/rvfi_shadow_regfile.sv
// Shadow copy of the architectural register file, rebuilt from retired rd writes.
// Read port j belongs to channel j/2 and sees writes from lower channels in the same cycle.
module rvfi_shadow_regfile
  import rvfi_mon_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NRET = 2
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     commit_i,
  input  logic [NRET-1:0]          wr_en_i,
  input  logic [NRET*5-1:0]        wr_addr_i,
  input  logic [NRET*XLEN-1:0]     wr_data_i,
  input  logic [2*NRET*5-1:0]      rd_addr_i,
  output logic [2*NRET*XLEN-1:0]   rd_data_o,
  output logic [2*NRET-1:0]        rd_valid_o
);

  logic [XLEN-1:0] regs_q [32];
  logic [XLEN-1:0] regs_d [32];
  logic [31:0]     vld_q, vld_d;

  logic [4:0]      ra;
  logic [XLEN-1:0] rdat;
  logic            rvld;

  // x0 reads as a known zero so the caller can use one comparison for every register.
  always_comb begin
    rd_data_o  = '0;
    rd_valid_o = '0;
    ra         = '0;
    rdat       = '0;
    rvld       = 1'b0;
    for (int j = 0; j < 2 * NRET; j++) begin
      ra   = rd_addr_i[j*5 +: 5];
      rdat = regs_q[ra];
      rvld = vld_q[ra];
      for (int k = 0; k < j / 2; k++) begin
        if (wr_en_i[k] && (wr_addr_i[k*5 +: 5] == ra)) begin
          rdat = wr_data_i[k*XLEN +: XLEN];
          rvld = 1'b1;
        end
      end
      if (ra == 5'd0) begin
        rdat = '0;
        rvld = 1'b1;
      end
      rd_data_o[j*XLEN +: XLEN] = rdat;
      rd_valid_o[j]             = rvld;
    end
  end

  always_comb begin
    regs_d = regs_q;
    vld_d  = vld_q;
    if (commit_i) begin
      for (int k = 0; k < NRET; k++) begin
        if (wr_en_i[k]) begin
          regs_d[wr_addr_i[k*5 +: 5]] = wr_data_i[k*XLEN +: XLEN];
          vld_d[wr_addr_i[k*5 +: 5]]  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    regs_q <= regs_d;
    if (!resetn) begin
      vld_q <= '0;
    end else begin
      vld_q <= vld_d;
    end
  end

endmodule

// File: rtl/rvfi_retire_monitor.sv
// RVFI retirement checker: walks the retire channels in order, latches the first violation
// as a sticky error and counts clean retirements.
module rvfi_retire_monitor
  import rvfi_mon_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned NRET       = 2,
  parameter int unsigned TIMEOUT    = 64,
  parameter int unsigned CHECK_REGS = 1
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [NRET-1:0]        rvfi_valid,
  input  logic [NRET*ORDER_W-1:0] rvfi_order,
  input  logic [NRET-1:0]        rvfi_trap,
  input  logic [NRET-1:0]        rvfi_halt,
  input  logic [NRET*XLEN-1:0]   rvfi_pc_rdata,
  input  logic [NRET*XLEN-1:0]   rvfi_pc_wdata,
  input  logic [NRET*5-1:0]      rvfi_rs1_addr,
  input  logic [NRET*5-1:0]      rvfi_rs2_addr,
  input  logic [NRET*XLEN-1:0]   rvfi_rs1_rdata,
  input  logic [NRET*XLEN-1:0]   rvfi_rs2_rdata,
  input  logic [NRET*5-1:0]      rvfi_rd_addr,
  input  logic [NRET*XLEN-1:0]   rvfi_rd_wdata,
  output logic                   err,
  output logic [3:0]             err_code,
  output logic [1:0]             err_chan,
  output logic [31:0]            retire_count,
  output logic                   halted
);

  localparam int unsigned IdleW = $clog2(TIMEOUT + 1);
  localparam int unsigned CntW  = $clog2(NRET + 1);

  state_e             state_q, state_d;
  logic [ORDER_W-1:0] order_q, order_d;
  logic [XLEN-1:0]    pc_q, pc_d;
  logic               pc_en_q, pc_en_d;
  logic [IdleW-1:0]   idle_q, idle_d;
  logic [31:0]        count_q, count_d;
  logic               halted_q, halted_d;
  logic               err_q, err_d;
  err_e               code_q, code_d;
  logic [1:0]         chan_q, chan_d;

  logic [NRET-1:0]        wr_en;
  logic [2*NRET*5-1:0]    rs_addr;
  logic [2*NRET*XLEN-1:0] rs_data;
  logic [2*NRET-1:0]      rs_valid;
  logic                   commit;

  err_e               first_code, ch_code;
  logic [1:0]         first_chan, valid_chan;
  logic [ORDER_W-1:0] exp_order;
  logic [XLEN-1:0]    exp_pc;
  logic               exp_pc_en, prev_valid, any_halt, found_valid;
  logic [CntW-1:0]    n_valid;

  always_comb begin
    wr_en   = '0;
    rs_addr = '0;
    for (int i = 0; i < NRET; i++) begin
      wr_en[i] = rvfi_valid[i] && !rvfi_trap[i] && (rvfi_rd_addr[i*5 +: 5] != 5'd0);
      rs_addr[(2*i)*5 +: 5]   = rvfi_rs1_addr[i*5 +: 5];
      rs_addr[(2*i+1)*5 +: 5] = rvfi_rs2_addr[i*5 +: 5];
    end
  end

  // Shadow state only advances on a clean RUN cycle; once in ERROR it no longer matters.
  assign commit = (state_q == StRun) && (first_code == ErrNone);

  rvfi_shadow_regfile #(
    .XLEN (XLEN),
    .NRET (NRET)
  ) u_shadow (
    .clk        (clk),
    .resetn     (resetn),
    .commit_i   (commit),
    .wr_en_i    (wr_en),
    .wr_addr_i  (rvfi_rd_addr),
    .wr_data_i  (rvfi_rd_wdata),
    .rd_addr_i  (rs_addr),
    .rd_data_o  (rs_data),
    .rd_valid_o (rs_valid)
  );

  always_comb begin
    first_code  = ErrNone;
    ch_code     = ErrNone;
    first_chan  = '0;
    valid_chan  = '0;
    found_valid = 1'b0;
    exp_order   = order_q;
    exp_pc      = pc_q;
    exp_pc_en   = pc_en_q;
    prev_valid  = 1'b1;
    any_halt    = 1'b0;
    n_valid     = '0;
    for (int i = 0; i < NRET; i++) begin
      ch_code = ErrNone;
      if (rvfi_valid[i]) begin
        if (rvfi_order[i*ORDER_W +: ORDER_W] != exp_order) begin
          ch_code = ErrOrder;
        end else if (!prev_valid) begin
          ch_code = ErrGap;
        end else if (exp_pc_en && (rvfi_pc_rdata[i*XLEN +: XLEN] != exp_pc)) begin
          ch_code = ErrPc;
        end else if ((CHECK_REGS != 0) && rs_valid[2*i] &&
                     (rvfi_rs1_rdata[i*XLEN +: XLEN] != rs_data[(2*i)*XLEN +: XLEN])) begin
          ch_code = ErrRs1;
        end else if ((CHECK_REGS != 0) && rs_valid[2*i+1] &&
                     (rvfi_rs2_rdata[i*XLEN +: XLEN] != rs_data[(2*i+1)*XLEN +: XLEN])) begin
          ch_code = ErrRs2;
        end else if ((rvfi_rd_addr[i*5 +: 5] == 5'd0) && (rvfi_rd_wdata[i*XLEN +: XLEN] != '0)) begin
          ch_code = ErrX0Wr;
        end
        if ((ch_code != ErrNone) && (first_code == ErrNone)) begin
          first_code = ch_code;
          first_chan = 2'(i);
        end
        if (!found_valid) begin
          found_valid = 1'b1;
          valid_chan  = 2'(i);
        end
        exp_order = exp_order + ORDER_W'(1);
        exp_pc    = rvfi_pc_wdata[i*XLEN +: XLEN];
        exp_pc_en = 1'b1;
        any_halt  = any_halt | rvfi_halt[i];
        n_valid   = n_valid + CntW'(1);
      end
      prev_valid = rvfi_valid[i];
    end
  end

  always_comb begin
    state_d  = state_q;
    order_d  = order_q;
    pc_d     = pc_q;
    pc_en_d  = pc_en_q;
    idle_d   = idle_q;
    count_d  = count_q;
    halted_d = halted_q;
    err_d    = err_q;
    code_d   = code_q;
    chan_d   = chan_q;
    unique case (state_q)
      StRun: begin
        if (|rvfi_valid) begin
          idle_d = '0;
          if (first_code != ErrNone) begin
            state_d = StError;
            err_d   = 1'b1;
            code_d  = first_code;
            chan_d  = first_chan;
          end else begin
            order_d = exp_order;
            pc_d    = exp_pc;
            pc_en_d = exp_pc_en;
            count_d = count_q + 32'(n_valid);
            if (any_halt) begin
              state_d  = StHalted;
              halted_d = 1'b1;
            end
          end
        end else begin
          idle_d = idle_q + IdleW'(1);
          if (idle_d == IdleW'(TIMEOUT)) begin
            state_d = StError;
            err_d   = 1'b1;
            code_d  = ErrTimeout;
            chan_d  = 2'd0;
          end
        end
      end
      StHalted: begin
        if (|rvfi_valid) begin
          state_d = StError;
          err_d   = 1'b1;
          code_d  = ErrPostHalt;
          chan_d  = valid_chan;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= StRun;
      order_q  <= '0;
      pc_q     <= '0;
      pc_en_q  <= 1'b0;
      idle_q   <= '0;
      count_q  <= '0;
      halted_q <= 1'b0;
      err_q    <= 1'b0;
      code_q   <= ErrNone;
      chan_q   <= '0;
    end else begin
      state_q  <= state_d;
      order_q  <= order_d;
      pc_q     <= pc_d;
      pc_en_q  <= pc_en_d;
      idle_q   <= idle_d;
      count_q  <= count_d;
      halted_q <= halted_d;
      err_q    <= err_d;
      code_q   <= code_d;
      chan_q   <= chan_d;
    end
  end

  assign err          = err_q;
  assign err_code     = code_q;
  assign err_chan     = chan_q;
  assign retire_count = count_q;
  assign halted       = halted_q;

endmodule
